// File: rtl/cpu_prog_loader_pkg.sv
// rtl/cpu_prog_loader_pkg.sv - shared constants and state encoding for the program loader
package cpu_prog_loader_pkg;

    localparam logic [7:0] LOADER_SYNC = 8'hA5;

    typedef enum logic [2:0] {
        HUNT   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        RUN    = 3'd5,
        ERROR  = 3'd6
    } loader_state_t;

endpackage

// File: rtl/cpu_prog_loader_if.sv
// rtl/cpu_prog_loader_if.sv - byte stream in, instruction RAM write port and CPU control out
interface cpu_prog_loader_if #(
    parameter int width       = 16,
    parameter int iaddr_width = 10
);
    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic                   rx_ready;
    logic [iaddr_width-1:0] iwaddr;
    logic [width-1:0]       iwdata;
    logic                   iwrite;
    logic                   cpu_reset;
    logic                   done;
    logic                   error;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, iwaddr, iwdata, iwrite, cpu_reset, done, error
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, iwaddr, iwdata, iwrite, cpu_reset, done, error
    );
endinterface

// File: rtl/cpu_prog_loader_word_asm.sv
// rtl/cpu_prog_loader_word_asm.sv - packs MSB-first bytes into instruction words
module loader_word_asm #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             word_done,
    output logic [width-1:0] word
);
    localparam int BPW = width / 8;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CW-1:0] byte_cnt;

    assign word_done = byte_valid && (byte_cnt == CW'(BPW - 1));

    // word is combinational so the completed value is available on the accepting clock
    generate
        if (BPW == 1) begin : g_single
            assign word = byte_data;
        end else begin : g_multi
            logic [width-9:0] sreg;
            assign word = {sreg, byte_data};
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sreg <= '0;
                end else if (byte_valid) begin
                    sreg <= word[width-9:0];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
        end else if (byte_valid) begin
            byte_cnt <= word_done ? '0 : byte_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/cpu_prog_loader.sv
// rtl/cpu_prog_loader.sv - framed byte stream to instruction RAM loader holding the CPU in reset
module cpu_prog_loader
    import cpu_prog_loader_pkg::*;
#(
    parameter int width       = 16,
    parameter int iaddr_width = 10
) (
    input  logic               clk,
    input  logic               reset,
    cpu_prog_loader_if.master  bus
);
    localparam int          CW      = iaddr_width + 1;
    localparam int unsigned MAX_LEN = 32'd1 << iaddr_width;

    loader_state_t          state, next_state;
    logic                   rx_ready_q, cpu_reset_q, done_q, error_q, iwrite_q;
    logic                   cpu_reset_d, done_d, error_d;
    logic [iaddr_width-1:0] iwaddr_q;
    logic [width-1:0]       iwdata_q;
    logic [7:0]             len_hi;
    logic [15:0]            len;
    logic [15:0]            len_full;
    logic [7:0]             csum;
    logic [7:0]             csum_next;
    logic [CW-1:0]          word_cnt;
    logic                   accept, word_done, last_word;
    logic [width-1:0]       word;

    assign accept    = bus.rx_valid & rx_ready_q;
    assign len_full  = {len_hi, bus.rx_data};
    assign csum_next = csum + bus.rx_data;
    assign last_word = (32'(word_cnt) + 32'd1) == 32'(len);

    loader_word_asm #(.width(width)) u_word_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (accept && (state == LEN_LO)),
        .byte_valid (accept && (state == DATA)),
        .byte_data  (bus.rx_data),
        .word_done  (word_done),
        .word       (word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= HUNT;
            rx_ready_q  <= 1'b0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state       <= next_state;
            rx_ready_q  <= 1'b1;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // SYNC is only recognised between frames; inside a frame 0xA5 is plain data
    always_comb begin
        next_state = state;
        if (accept) begin
            case (state)
                HUNT, RUN, ERROR: if (bus.rx_data == LOADER_SYNC) next_state = LEN_HI;
                LEN_HI:           next_state = LEN_LO;
                LEN_LO: begin
                    if (32'(len_full) > MAX_LEN)  next_state = ERROR;
                    else if (len_full == 16'd0)   next_state = CSUM;
                    else                          next_state = DATA;
                end
                DATA:             if (word_done && last_word) next_state = CSUM;
                CSUM:             next_state = (csum_next == 8'h00) ? RUN : ERROR;
                default:          next_state = HUNT;
            endcase
        end
    end

    // Outputs are registered from next_state so cpu_reset releases cleanly on RUN entry
    always_comb begin
        cpu_reset_d = (next_state != RUN);
        done_d      = (next_state == RUN);
        error_d     = (next_state == ERROR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_hi   <= '0;
            len      <= '0;
            csum     <= '0;
            word_cnt <= '0;
            iwaddr_q <= '0;
            iwdata_q <= '0;
            iwrite_q <= 1'b0;
        end else begin
            iwrite_q <= 1'b0;
            if (accept) begin
                case (state)
                    HUNT, RUN, ERROR: if (bus.rx_data == LOADER_SYNC) csum <= '0;
                    LEN_HI: begin
                        len_hi <= bus.rx_data;
                        csum   <= csum_next;
                    end
                    LEN_LO: begin
                        len      <= len_full;
                        csum     <= csum_next;
                        word_cnt <= '0;
                    end
                    DATA, CSUM: csum <= csum_next;
                    default: ;
                endcase
            end
            if ((state == DATA) && word_done) begin
                iwrite_q <= 1'b1;
                iwdata_q <= word;
                iwaddr_q <= word_cnt[iaddr_width-1:0];
                word_cnt <= word_cnt + CW'(1);
            end
        end
    end

    assign bus.rx_ready  = rx_ready_q;
    assign bus.iwaddr    = iwaddr_q;
    assign bus.iwdata    = iwdata_q;
    assign bus.iwrite    = iwrite_q;
    assign bus.cpu_reset = cpu_reset_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
endmodule

// File: tb/tb_cpu_prog_loader.sv
// tb/tb_cpu_prog_loader.sv - directed frames with a write scoreboard for cpu_prog_loader
module tb_cpu_prog_loader;
    localparam int W = 16;
    localparam int A = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cpu_prog_loader_if #(.width(W), .iaddr_width(A)) bus ();

    cpu_prog_loader #(.width(W), .iaddr_width(A)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [A-1:0] addr;
        logic [W-1:0] data;
    } wr_t;

    wr_t          exp_q[$];
    logic [7:0]   frame_q[$];
    logic [W-1:0] words[$];
    int           checks = 0;
    int           errors = 0;
    int           extra_writes = 0;
    int           write_count = 0;
    int           wc0;
    logic [A-1:0] last_waddr = '0;
    bit           gap_mode = 1'b0;
    wr_t          mon_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.iwrite === 1'b1) begin
            write_count++;
            last_waddr = bus.iwaddr;
            if (exp_q.size() == 0) begin
                extra_writes++;
            end else begin
                mon_e = exp_q.pop_front();
                chk("waddr", 32'(bus.iwaddr), 32'(mon_e.addr));
                chk("wdata", 32'(bus.iwdata), 32'(mon_e.data));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        if (gap_mode) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                bus.rx_valid = 1'b0;
            end
        end
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
        end
    endtask

    task automatic set_words(input int n, input logic [W-1:0] seed);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back(W'(seed + W'(i) * W'(16'h0137)));
    endtask

    // Builds a frame from words[], queues its expected RAM writes, appends the checksum
    task automatic build_frame(input int nwords, input bit bad);
        logic [7:0] sum;
        logic [W-1:0] w;
        frame_q.delete();
        sum = 8'h00;
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'(nwords >> 8));
        frame_q.push_back(8'(nwords));
        sum = 8'(nwords >> 8) + 8'(nwords);
        for (int i = 0; i < nwords; i++) begin
            w = words[i];
            frame_q.push_back(w[15:8]);
            frame_q.push_back(w[7:0]);
            sum = sum + w[15:8] + w[7:0];
            exp_q.push_back('{addr: A'(i), data: w});
        end
        sum = 8'h00 - sum;
        if (bad) sum = sum + 8'h01;
        frame_q.push_back(sum);
    endtask

    task automatic send_frame_q(input int from);
        for (int i = from; i < frame_q.size(); i++) begin
            send_byte(frame_q[i]);
            if (i == frame_q.size() - 1) chk("cpu_reset_load", 32'(bus.cpu_reset), 32'd1);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_rx_ready"},  32'(bus.rx_ready),  32'd0);
        chk({tag, "_iwaddr"},    32'(bus.iwaddr),    32'd0);
        chk({tag, "_iwdata"},    32'(bus.iwdata),    32'd0);
        chk({tag, "_iwrite"},    32'(bus.iwrite),    32'd0);
        chk({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 32'd1);
        chk({tag, "_done"},      32'(bus.done),      32'd0);
        chk({tag, "_error"},     32'(bus.error),     32'd0);
    endtask

    task automatic t1_words();
        words.delete();
        words.push_back(16'h1234);
        words.push_back(16'h5678);
        words.push_back(16'h9ABC);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        chk_reset_values("rst");
        reset = 1'b0;
        @(negedge clk);
        chk("rx_ready_up", 32'(bus.rx_ready), 32'd1);

        // 1: three-word frame
        t1_words();
        build_frame(3, 1'b0);
        send_frame_q(0);
        idle(1);
        chk("t1_cpu_reset", 32'(bus.cpu_reset), 32'd0);
        chk("t1_done",      32'(bus.done),      32'd1);
        chk("t1_error",     32'(bus.error),     32'd0);
        idle(2);
        chk("t1_pending", 32'(exp_q.size()), 32'd0);

        // 2: empty program
        wc0 = write_count;
        words.delete();
        build_frame(0, 1'b0);
        send_frame_q(0);
        idle(1);
        chk("t2_done",      32'(bus.done),      32'd1);
        chk("t2_cpu_reset", 32'(bus.cpu_reset), 32'd0);
        chk("t2_writes",    32'(write_count),   32'(wc0));

        // 3: bad checksum, then recovery
        t1_words();
        build_frame(3, 1'b1);
        send_frame_q(0);
        idle(1);
        chk("t3_error",     32'(bus.error),     32'd1);
        chk("t3_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("t3_done",      32'(bus.done),      32'd0);
        idle(2);
        chk("t3_pending", 32'(exp_q.size()), 32'd0);
        set_words(5, 16'h4000);
        build_frame(5, 1'b0);
        send_frame_q(0);
        idle(1);
        chk("t3_good_done",  32'(bus.done),  32'd1);
        chk("t3_good_error", 32'(bus.error), 32'd0);

        // 4: oversize length, then a full-size program
        wc0 = write_count;
        frame_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'h04);
        frame_q.push_back(8'h01);
        send_frame_q(0);
        idle(1);
        chk("t4_error",     32'(bus.error),     32'd1);
        chk("t4_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("t4_writes",    32'(write_count),   32'(wc0));
        set_words(1024, 16'h8001);
        build_frame(1024, 1'b0);
        send_frame_q(0);
        idle(2);
        chk("t4_done",      32'(bus.done),      32'd1);
        chk("t4_last_addr", 32'(last_waddr),    32'h3FF);
        chk("t4_pending",   32'(exp_q.size()),  32'd0);

        // 5: stray byte in RUN, then reload
        send_byte(8'h55);
        idle(1);
        chk("t5_ign_done",      32'(bus.done),      32'd1);
        chk("t5_ign_cpu_reset", 32'(bus.cpu_reset), 32'd0);
        set_words(1, 16'hBEEF);
        build_frame(1, 1'b0);
        send_byte(frame_q[0]);
        idle(1);
        chk("t5_sync_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("t5_sync_done",      32'(bus.done),      32'd0);
        send_frame_q(1);
        idle(1);
        chk("t5_done",      32'(bus.done),      32'd1);
        chk("t5_cpu_reset", 32'(bus.cpu_reset), 32'd0);

        // 6: reset mid-frame, garbage, then a gapped reload
        exp_q.push_back('{addr: A'(0), data: 16'h1234});
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'h12);
        send_byte(8'h34);
        idle(1);
        #1 reset = 1'b1;
        #1 chk_reset_values("mid");
        @(negedge clk);
        reset = 1'b0;
        wc0 = write_count;
        gap_mode = 1'b1;
        send_byte(8'h55);
        send_byte(8'h00);
        send_byte(8'h12);
        send_byte(8'h34);
        idle(2);
        chk("t6_hunt_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("t6_hunt_done",      32'(bus.done),      32'd0);
        chk("t6_hunt_error",     32'(bus.error),     32'd0);
        chk("t6_hunt_writes",    32'(write_count),   32'(wc0));
        t1_words();
        build_frame(3, 1'b0);
        send_frame_q(0);
        idle(1);
        chk("t6_done",      32'(bus.done),      32'd1);
        chk("t6_cpu_reset", 32'(bus.cpu_reset), 32'd0);
        idle(2);
        chk("t6_pending", 32'(exp_q.size()),  32'd0);
        chk("extra_writes", 32'(extra_writes), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
